// File: rtl/mips_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single Avalon-style memory bus.
// Alternating priority on ties, misalignment trapping, and a bounded wait-state timeout.
module mips_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_XFER = 2'd1;
  localparam logic [1:0] D_XFER = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  // True when the wait cycle being counted now is the last one tolerated.
  function automatic logic timed_out(input logic [7:0] count);
    return ({1'b0, count} + 9'd1) >= TIMEOUT_LIM;
  endfunction

  logic [1:0]  state, state_nxt;
  logic        last_grant;   // 0 = fetch port, 1 = data port
  logic        gnt_port;     // port owning the current transaction
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        write_q;

  logic        d_req, grant_data, bad, req_any;
  logic        resp_load, resp_err, resp_port;
  logic [31:0] resp_rdata;
  logic        xfer;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    d_req      = d_read | d_write;
    req_any    = i_req | d_req;
    grant_data = d_req & (~i_req | ~last_grant);
    bad        = grant_data ? ((d_addr[1:0] != 2'b00) | (d_read & d_write))
                            : (i_addr[1:0] != 2'b00);
    resp_port  = (state == IDLE) ? grant_data : gnt_port;
    case (state)
      IDLE: begin
        if (req_any) begin
          cnt_nxt = '0;
          if (bad) begin
            state_nxt = RESP;
            resp_load = 1'b1;
            resp_err  = 1'b1;
          end else begin
            state_nxt = grant_data ? D_XFER : I_XFER;
          end
        end
      end
      I_XFER, D_XFER: begin
        if (!m_waitrequest) begin
          state_nxt  = RESP;
          resp_load  = 1'b1;
          resp_rdata = write_q ? 32'd0 : m_readdata;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (timed_out(cnt)) begin
            state_nxt = RESP;
            resp_load = 1'b1;
            resp_err  = 1'b1;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and response state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      gnt_port   <= 1'b0;
      cnt        <= '0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_any) begin
        last_grant <= grant_data;
        gnt_port   <= grant_data;
      end
      if (resp_load) begin
        if (resp_port) begin
          d_rdata <= resp_rdata;
          d_err   <= resp_err;
        end else begin
          i_rdata <= resp_rdata;
          i_err   <= resp_err;
        end
      end
    end
  end

  // Transfer attributes captured at grant; only visible on the bus while in XFER
  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) begin
      addr_q  <= grant_data ? d_addr : i_addr;
      wdata_q <= (grant_data && d_write) ? d_wdata : 32'd0;
      be_q    <= (grant_data && d_write) ? d_byteenable : 4'b1111;
      write_q <= grant_data & d_write;
    end
  end

  assign xfer         = (state == I_XFER) | (state == D_XFER);
  assign m_read       = xfer & ~write_q;
  assign m_write      = xfer & write_q;
  assign m_address    = xfer ? addr_q  : 32'd0;
  assign m_writedata  = xfer ? wdata_q : 32'd0;
  assign m_byteenable = xfer ? be_q    : 4'd0;

  assign i_ack = (state == RESP) & ~gnt_port;
  assign d_ack = (state == RESP) & gnt_port;
  assign busy  = (state != IDLE);

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, max consecutive m_waitrequest=1 cycles tolerated per bus transfer (8-bit counter).
REQ-002 SHALL have ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  instruction-fetch read request
- i_addr  input  32  fetch byte address
- i_ack  output  1  one-cycle fetch completion pulse
- i_rdata  output  32  fetched word, valid with i_ack
- i_err  output  1  fetch error, valid with i_ack
- d_read  input  1  data load request
- d_write  input  1  data store request
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_byteenable  input  4  store byte lanes
- d_ack  output  1  one-cycle data completion pulse
- d_rdata  output  32  load word, valid with d_ack
- d_err  output  1  data error, valid with d_ack
- m_address  output  32  shared memory bus address
- m_read  output  1  bus read strobe
- m_write  output  1  bus write strobe
- m_writedata  output  32  bus write data
- m_byteenable  output  4  bus byte lanes
- m_readdata  input  32  bus read data
- m_waitrequest  input  1  bus stall, transfer completes in cycle it is 0
- busy  output  1  arbiter not in IDLE

Function
REQ-003 SHALL implement states IDLE, I_XFER, D_XFER, RESP.
REQ-004 IDLE: only i_req -> I_XFER; only d_read|d_write -> D_XFER; both -> grant port not granted last (last_grant register); none -> stay.
REQ-005 On grant SHALL register address, wdata, byteenable, direction; requester inputs ignored until next IDLE.
REQ-006 m_* SHALL be driven only from registered values in I_XFER/D_XFER; m_read, m_write, m_address, m_writedata, m_byteenable = 0 in IDLE and RESP.
REQ-007 Fetch: m_read=1, m_byteenable=4'b1111; data load: m_read=1, byteenable=4'b1111; data store: m_write=1, byteenable=d_byteenable.
REQ-008 XFER cycle with m_waitrequest=0 SHALL complete transfer, latch m_readdata (reads) and go RESP.
REQ-009 RESP SHALL pulse exactly one ack (granted port) for one cycle, then go IDLE; rdata/err outputs hold value until next ack of that port.
REQ-010 Zero-wait latency: request sampled cycle N, bus strobe cycle N+1, ack cycle N+2; each wait cycle adds one.
REQ-011 Requesters SHALL hold request until ack; request sampled in IDLE after RESP is treated as new request.
REQ-012 Misaligned address (addr[1:0]!=0) or d_read&d_write both 1: no bus transfer, IDLE -> RESP directly, err=1, rdata=0.
REQ-013 Timeout counter SHALL clear on entering XFER, increment per cycle with m_waitrequest=1; on reaching TIMEOUT, strobes drop next cycle, go RESP with err=1, rdata=0.
REQ-014 Store ack SHALL give d_rdata=0, d_err=0; successful load/fetch err=0.
REQ-015 last_grant SHALL update on every grant, including error grants.
REQ-016 busy SHALL be 1 in any state except IDLE.

Reset
REQ-017 reset=0 SHALL immediately (asynchronously) force IDLE, last_grant=instruction, timeout counter=0, all outputs 0.
REQ-018 Reset mid-transfer SHALL abandon transfer with no ack; m_read/m_write drop without waiting for clk.
REQ-019 After reset release, first simultaneous request SHALL grant data port.

Verification
REQ-020 Bench SHALL cover:
- i_req=1, i_addr=0xBFC00000, waitrequest=0, m_readdata=0x24020005 -> m_read cycle N+1, i_ack cycle N+2, i_rdata=0x24020005, i_err=0.
- Same cycle i_req and d_write (addr 0x100, wdata 0xDEADBEEF, be 4'b0011) after reset -> store first (m_write, be 0011), d_ack, then fetch, i_ack; next tie grants data.
- d_read addr 0x2000, waitrequest=1 for 3 cycles -> d_ack at N+5, d_rdata = m_readdata on completion cycle.
- d_addr=0x1002 d_read -> no m_read, d_ack cycle N+1, d_err=1, d_rdata=0; d_read&d_write -> same.
- TIMEOUT=4, waitrequest stuck 1 -> strobe 4 cycles, then err ack, busy returns 0.
- reset=0 mid-D_XFER between clock edges -> m_write, busy 0 immediately, no d_ack.
